// File: rtl/serial_rx_ctrl.sv
// serial_rx_ctrl: oversampled serial receiver, MSB first on the line,
// with a one-word holding register and framing/overrun pulses.
module serial_rx_ctrl #(
    parameter int p_width = 8,
    parameter int p_div   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rx,
    input  logic               i_rdy,
    output logic [p_width-1:0] o_val,
    output logic               o_vld,
    output logic               o_err,
    output logic               o_ovf,
    output logic               o_bsy
);

    localparam int cw = $clog2(p_div);
    localparam int bw = (p_width > 1) ? $clog2(p_width) : 1;

    localparam logic [cw-1:0] half_end = cw'(p_div / 2 - 1);
    localparam logic [cw-1:0] full_end = cw'(p_div - 1);
    localparam logic [bw-1:0] last_bit = bw'(p_width - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [cw-1:0]      cnt;
    logic [cw-1:0]      cnt_n;
    logic [bw-1:0]      bit_cnt;
    logic [bw-1:0]      bit_n;
    logic [p_width-1:0] sr;
    logic [p_width-1:0] sr_n;
    logic               rx_m;
    logic               rx_s;
    logic               stop_ok;
    logic               stop_bad;
    logic               free;

    // Synchronizer idles high so reset never looks like a start bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= i_rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            sr      <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            sr      <= sr_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bit_n    = bit_cnt;
        sr_n     = sr;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == half_end) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == full_end) begin
                    cnt_n = '0;
                    sr_n  = {sr[p_width-2:0], rx_s};
                    if (bit_cnt == last_bit) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == full_end) begin
                    cnt_n    = '0;
                    state_n  = IDLE;
                    stop_ok  = rx_s;
                    stop_bad = !rx_s;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The holding register frees up in the same cycle it is accepted.
    assign free = !o_vld || i_rdy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_val <= '0;
            o_vld <= 1'b0;
            o_err <= 1'b0;
            o_ovf <= 1'b0;
        end else begin
            o_err <= stop_bad;
            o_ovf <= stop_ok && !free;
            if (stop_ok && free) begin
                o_val <= sr;
                o_vld <= 1'b1;
            end else if (o_vld && i_rdy) begin
                o_vld <= 1'b0;
            end
        end
    end

    assign o_bsy = (state != IDLE);

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// tb_serial_rx_ctrl: scoreboard bench for serial_rx_ctrl
// with p_width=8, p_div=4.
module tb_serial_rx_ctrl;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx  = 1'b1;
    logic         rdy = 1'b1;
    logic [W-1:0] val;
    logic         vld;
    logic         err;
    logic         ovf;
    logic         bsy;

    serial_rx_ctrl #(.p_width(W), .p_div(D)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_rx (rx),
        .i_rdy(rdy),
        .o_val(val),
        .o_vld(vld),
        .o_err(err),
        .o_ovf(ovf),
        .o_bsy(bsy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int rise_cyc = 0;
    int vld_cyc = 0;
    int err_cyc = 0;
    int ovf_cyc = 0;
    int bsy_cyc = 0;
    int pops = 0;
    logic [W-1:0] sb[$];
    logic         prev_vld = 1'b0;
    logic         prev_acc = 1'b0;
    logic [W-1:0] prev_val = '0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (vld) vld_cyc++;
        if (err) err_cyc++;
        if (ovf) ovf_cyc++;
        if (bsy) bsy_cyc++;
        if (err && ovf) check("err_ovf_excl", 1, 0);
        if (vld && !prev_vld) rise_cyc = cyc;
        if (prev_vld && !prev_acc && vld && val != prev_val)
            check("val_stable", val, prev_val);
        if (vld && rdy && !rst) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 0, 1);
            end else begin
                e = sb.pop_front();
                check("word", val, e);
                pops++;
            end
        end
        prev_vld = vld;
        prev_acc = vld && rdy;
        prev_val = val;
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(logic [W-1:0] v, logic stop);
        rx = 1'b0;
        fall_cyc = cyc;
        tick(D);
        for (int i = W - 1; i >= 0; i--) begin
            rx = v[i];
            tick(D);
        end
        rx = stop;
        tick(D);
        rx = 1'b1;
    endtask

    task automatic check_zero(string tag);
        check({tag, "_val"}, val, 0);
        check({tag, "_vld"}, vld, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_bsy"}, bsy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int p0, v0, e0, o0, b0, lat;

        rst = 1'b1;
        tick(3);
        check_zero("reset");
        rst = 1'b0;
        tick(4);

        p0 = pops; v0 = vld_cyc; e0 = err_cyc; o0 = ovf_cyc;
        sb.push_back(8'hA5);
        send(8'hA5, 1'b1);
        tick(6);
        lat = rise_cyc - fall_cyc;
        check("a5_pops", pops - p0, 1);
        check("a5_vld_cycles", vld_cyc - v0, 1);
        check("a5_err", err_cyc - e0, 0);
        check("a5_ovf", ovf_cyc - o0, 0);
        check("a5_latency", (lat >= 40 && lat <= 42), 1);
        check("a5_val", val, 8'hA5);

        v0 = vld_cyc; e0 = err_cyc; b0 = bsy_cyc;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(2 + D / 2 + 2);
        check("glitch_bsy_seen", bsy_cyc > b0, 1);
        check("glitch_bsy_low", bsy, 0);
        check("glitch_vld", vld_cyc - v0, 0);
        check("glitch_err", err_cyc - e0, 0);

        v0 = vld_cyc; e0 = err_cyc; o0 = ovf_cyc;
        send(8'h3C, 1'b0);
        tick(8);
        check("stop_err_pulse", err_cyc - e0, 1);
        check("stop_err_vld", vld_cyc - v0, 0);
        check("stop_err_ovf", ovf_cyc - o0, 0);
        check("stop_err_val", val, 8'hA5);

        rdy = 1'b0;
        p0 = pops; e0 = err_cyc; o0 = ovf_cyc;
        sb.push_back(8'h11);
        send(8'h11, 1'b1);
        tick(4);
        check("ovf_first_vld", vld, 1);
        check("ovf_first_none", ovf_cyc - o0, 0);
        send(8'h22, 1'b1);
        tick(4);
        check("ovf_pulse", ovf_cyc - o0, 1);
        check("ovf_err", err_cyc - e0, 0);
        check("ovf_hold_vld", vld, 1);
        check("ovf_hold_val", val, 8'h11);
        check("ovf_no_pop", pops - p0, 0);
        rdy = 1'b1;
        tick(2);
        check("ovf_drain_pop", pops - p0, 1);
        check("ovf_drain_vld", vld, 0);
        check("ovf_drain_val", val, 8'h11);

        e0 = err_cyc; o0 = ovf_cyc; v0 = vld_cyc;
        fork
            send(8'hFF, 1'b1);
            begin
                tick(21);
                rst = 1'b1;
                tick(2);
                check_zero("midrst");
                rst = 1'b0;
            end
        join
        tick(6);
        check("midrst_err", err_cyc - e0, 0);
        check("midrst_ovf", ovf_cyc - o0, 0);
        check("midrst_vld", vld_cyc - v0, 0);

        p0 = pops; v0 = vld_cyc;
        sb.push_back(8'h5A);
        send(8'h5A, 1'b1);
        tick(6);
        check("5a_pops", pops - p0, 1);
        check("5a_vld_cycles", vld_cyc - v0, 1);
        check("5a_val", val, 8'h5A);

        p0 = pops; v0 = vld_cyc; e0 = err_cyc; o0 = ovf_cyc;
        sb.push_back(8'h01);
        sb.push_back(8'h80);
        sb.push_back(8'hFF);
        send(8'h01, 1'b1);
        send(8'h80, 1'b1);
        send(8'hFF, 1'b1);
        tick(6);
        check("b2b_pops", pops - p0, 3);
        check("b2b_vld_cycles", vld_cyc - v0, 3);
        check("b2b_err", err_cyc - e0, 0);
        check("b2b_ovf", ovf_cyc - o0, 0);
        check("b2b_bsy", bsy, 0);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
